// File: rtl/b20_extend.sv
// Extension stage for the 20-bit filter-input enumerator: steps the enumerator,
// tests both next-bit extensions against the keystream bit, queues survivors in a FWFT FIFO.
module b20_extend #(
    parameter int unsigned DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        KS_BIT,
    output logic        ENUM_RSTn,
    output logic        ENUM_STB,
    input  logic [19:0] ENUM_KEY20,
    output logic [20:0] OUT_KEY21,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [16:0] CAND_CNT,
    output logic        BUSY,
    output logic        DONE
);

    localparam int unsigned KEY_W = 20;
    localparam int unsigned EXT_W = 21;
    localparam int unsigned CNT_W = 17;
    localparam int unsigned FET_W = 16;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    localparam logic [FET_W-1:0] N_CAND = 16'h8000;
    localparam logic [15:0]      FA_TBL = 16'h9E98;
    localparam logic [15:0]      FB_TBL = 16'hB48E;
    localparam logic [31:0]      FC_TBL = 32'hEC57E80A;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_STROBE, S_LOAD, S_PUSH0, S_PUSH1, S_DRAIN, S_FIN
    } state_t;

    // Crypto1 filter function; the 4-bit tables are indexed by the bit-reversed nibble
    function automatic logic fa(input logic [3:0] n);
        return FA_TBL[{n[0], n[1], n[2], n[3]}];
    endfunction

    function automatic logic fb(input logic [3:0] n);
        return FB_TBL[{n[0], n[1], n[2], n[3]}];
    endfunction

    function automatic logic filt(input logic [KEY_W-1:0] x);
        logic [4:0] sel;
        sel = {fa(x[3:0]), fb(x[7:4]), fa(x[11:8]), fa(x[15:12]), fb(x[19:16])};
        return FC_TBL[sel];
    endfunction

    state_t             state_q, state_d;
    logic               ks_q, ks_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               pass0_q, pass0_d, pass1_q, pass1_d;
    logic [FET_W-1:0]   fetched_q, fetched_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               busy_q, stb_q, rstn_q;
    logic               push_c, push_bit_c, pop_c, full_c;
    logic [EXT_W-1:0]   push_data_c;

    logic [EXT_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [EXT_W-1:0]   head_q;
    logic               valid_q;

    assign full_c      = (occ_q == OCC_W'(DEPTH));
    assign pop_c       = (occ_q != '0) && OUT_READY;
    assign push_data_c = {key_q, push_bit_c};

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        ks_d       = ks_q;
        key_d      = key_q;
        pass0_d    = pass0_q;
        pass1_d    = pass1_q;
        fetched_d  = fetched_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        push_c     = 1'b0;
        push_bit_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    ks_d      = KS_BIT;
                    cnt_d     = '0;
                    fetched_d = '0;
                    done_d    = 1'b0;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR:  state_d = S_STROBE;
            S_STROBE: begin
                fetched_d = fetched_q + FET_W'(1);
                state_d   = S_LOAD;
            end
            S_LOAD: begin
                key_d   = ENUM_KEY20;
                pass0_d = (filt({ENUM_KEY20[18:0], 1'b0}) == ks_q);
                pass1_d = (filt({ENUM_KEY20[18:0], 1'b1}) == ks_q);
                state_d = S_PUSH0;
            end
            S_PUSH0: begin
                if (!pass0_q) begin
                    state_d = S_PUSH1;
                end else if (!full_c) begin
                    push_c  = 1'b1;
                    state_d = S_PUSH1;
                end
            end
            S_PUSH1: begin
                push_bit_c = 1'b1;
                if (!pass1_q || !full_c) begin
                    push_c  = pass1_q;
                    state_d = (fetched_q == N_CAND) ? S_DRAIN : S_STROBE;
                end
            end
            S_DRAIN: begin
                if (occ_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (push_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        occ_d = occ_q + OCC_W'(push_c) - OCC_W'(pop_c);
    end

    // State, control and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            ks_q      <= 1'b0;
            key_q     <= '0;
            pass0_q   <= 1'b0;
            pass1_q   <= 1'b0;
            fetched_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            stb_q     <= 1'b0;
            rstn_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            ks_q      <= ks_d;
            key_q     <= key_d;
            pass0_q   <= pass0_d;
            pass1_q   <= pass1_d;
            fetched_q <= fetched_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            busy_q    <= !((state_d == S_IDLE) || (state_d == S_FIN));
            stb_q     <= (state_d == S_STROBE);
            rstn_q    <= (state_d != S_CLEAR);
        end
    end

    // FIFO storage; contents are irrelevant after a flush so no reset
    always_ff @(posedge CLK) begin
        if (push_c) begin
            mem[wr_ptr_q] <= push_data_c;
        end
    end

    // FIFO pointers and registered FWFT head
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_c && (occ_q == OCC_W'(pop_c))) begin
                head_q <= push_data_c;
            end else if (pop_c) begin
                head_q <= mem[rd_ptr_q + PTR_W'(1)];
            end
            occ_q   <= occ_d;
            valid_q <= (occ_d != '0);
        end
    end

    assign ENUM_RSTn = rstn_q;
    assign ENUM_STB  = stb_q;
    assign OUT_KEY21 = head_q;
    assign OUT_VALID = valid_q;
    assign CAND_CNT  = cnt_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_b20_extend.sv
// Self-checking bench for b20_extend: single-candidate vector table, backpressure,
// reset abort, and a full randomized run against a behavioural filter/enumerator model.
module tb_b20_extend;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        KS_BIT = 1'b0;
    logic        ENUM_RSTn;
    logic        ENUM_STB;
    logic [19:0] ENUM_KEY20;
    logic [20:0] OUT_KEY21;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [16:0] CAND_CNT;
    logic        BUSY;
    logic        DONE;

    b20_extend #(.DEPTH(16)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .KS_BIT    (KS_BIT),
        .ENUM_RSTn (ENUM_RSTn),
        .ENUM_STB  (ENUM_STB),
        .ENUM_KEY20(ENUM_KEY20),
        .OUT_KEY21 (OUT_KEY21),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .CAND_CNT  (CAND_CNT),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int stb_cnt = 0;
    int rstn_lo = 0;
    int pops = 0;
    bit sb_on = 1'b0;
    bit rand_ready = 1'b0;
    logic [20:0] exp_q[$];

    // Enumerator stand-in: constant key, or a reset-able sequence advanced by ENUM_STB
    bit          use_stub = 1'b0;
    logic [19:0] const_key = '0;
    logic [19:0] stub_key = '0;
    int unsigned stub_idx = 0;
    int unsigned seed = 0;

    function automatic logic [19:0] enum_key(input int unsigned i);
        return 20'((i * 40503) + seed);
    endfunction

    always @(posedge CLK) begin
        if (!ENUM_RSTn) begin
            stub_idx <= 0;
        end else if (ENUM_STB) begin
            stub_key <= enum_key(stub_idx);
            stub_idx <= stub_idx + 1;
        end
    end

    assign ENUM_KEY20 = use_stub ? stub_key : const_key;

    // Reference filter built from the table definitions with integer arithmetic
    function automatic int unsigned rev4(input int unsigned n);
        return ((n & 1) << 3) | ((n & 2) << 1) | ((n >> 1) & 2) | ((n >> 3) & 1);
    endfunction

    function automatic int unsigned tbit(input int unsigned c, input int unsigned i);
        return (c >> i) & 1;
    endfunction

    function automatic int unsigned model_f(input int unsigned x);
        int unsigned nib[5];
        int unsigned sel;
        for (int j = 0; j < 5; j++) nib[j] = (x >> (4 * j)) & 15;
        sel = tbit(32'h9E98, rev4(nib[0])) * 16 + tbit(32'hB48E, rev4(nib[1])) * 8
            + tbit(32'h9E98, rev4(nib[2])) * 4 + tbit(32'h9E98, rev4(nib[3])) * 2
            + tbit(32'hB48E, rev4(nib[4]));
        return tbit(32'hEC57E80A, sel);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_pop();
        logic [20:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pop_extra: got 0x%0h, want no entry", OUT_KEY21);
        end else begin
            e = exp_q.pop_front();
            chk("pop_data", 32'(OUT_KEY21), 32'(e));
        end
        pops++;
    endtask

    // One clock: drive, check a pending pop, advance to the next falling edge, count strobes
    task automatic step();
        if (rand_ready) OUT_READY = ($urandom_range(0, 3) != 0);
        if (sb_on && OUT_VALID && OUT_READY) check_pop();
        @(negedge CLK);
        if (ENUM_STB) stb_cnt++;
        if (!ENUM_RSTn) rstn_lo++;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
    endtask

    typedef struct {
        logic        ks;
        logic [19:0] key;
        int          n;
        logic [20:0] k0;
        logic [20:0] k1;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int s0;
        int r0;
        int model_cnt;
        bit got_done;
        logic ks;
        logic [19:0] k;

        vecs[0] = '{1'b0, 20'h00000, 2, 21'h000000, 21'h000001};
        vecs[1] = '{1'b1, 20'hFFFFF, 2, 21'h1FFFFE, 21'h1FFFFF};
        vecs[2] = '{1'b0, 20'hFFFFF, 0, 21'h000000, 21'h000000};
        for (int i = 3; i < 8; i++) begin
            vecs[i].ks  = 1'($urandom_range(0, 1));
            vecs[i].key = 20'($urandom);
            vecs[i].n   = 0;
            vecs[i].k0  = '0;
            vecs[i].k1  = '0;
            for (int b = 0; b < 2; b++) begin
                if (model_f(((int'(vecs[i].key) << 1) | b) & 32'hFFFFF) == vecs[i].ks) begin
                    if (vecs[i].n == 0) vecs[i].k0 = 21'((int'(vecs[i].key) << 1) | b);
                    else                vecs[i].k1 = 21'((int'(vecs[i].key) << 1) | b);
                    vecs[i].n++;
                end
            end
        end

        do_reset();
        chk("rst_enum_rstn", 32'(ENUM_RSTn), 1);
        chk("rst_enum_stb", 32'(ENUM_STB), 0);
        chk("rst_out_valid", 32'(OUT_VALID), 0);
        chk("rst_cand_cnt", 32'(CAND_CNT), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_done", 32'(DONE), 0);
        chk("rst_out_key", 32'(OUT_KEY21), 0);

        // Single-candidate vectors
        foreach (vecs[i]) begin
            const_key = vecs[i].key;
            KS_BIT = vecs[i].ks;
            START = 1'b1;
            step();
            START = 1'b0;
            chk("vec_busy", 32'(BUSY), 1);
            chk("vec_enum_rstn_low", 32'(ENUM_RSTn), 0);
            step();
            chk("vec_stb_first", 32'(ENUM_STB), 1);
            repeat (4) step();
            chk("vec_stb_next", 32'(ENUM_STB), 1);
            chk("vec_cand_cnt", 32'(CAND_CNT), 32'(vecs[i].n));
            chk("vec_valid", 32'(OUT_VALID), 32'(vecs[i].n != 0));
            if (vecs[i].n != 0) chk("vec_head0", 32'(OUT_KEY21), 32'(vecs[i].k0));
            OUT_READY = 1'b1;
            step();
            OUT_READY = 1'b0;
            if (vecs[i].n == 2) chk("vec_head1", 32'(OUT_KEY21), 32'(vecs[i].k1));
            else                chk("vec_empty", 32'(OUT_VALID), 0);
            do_reset();
        end

        // Backpressure: fill FIFO, stall, then drain in order
        const_key = 20'h00000;
        KS_BIT = 1'b0;
        s0 = stb_cnt;
        START = 1'b1;
        step();
        START = 1'b0;
        repeat (59) step();
        chk("bp_stb_pulses", 32'(stb_cnt - s0), 9);
        chk("bp_cand_cnt", 32'(CAND_CNT), 16);
        chk("bp_valid", 32'(OUT_VALID), 1);
        chk("bp_busy", 32'(BUSY), 1);
        s0 = stb_cnt;
        repeat (10) step();
        chk("bp_stalled", 32'(stb_cnt - s0), 0);
        for (int i = 0; i < 200; i++) exp_q.push_back(21'(i % 2));
        pops = 0;
        sb_on = 1'b1;
        OUT_READY = 1'b1;
        repeat (40) step();
        OUT_READY = 1'b0;
        sb_on = 1'b0;
        chk("bp_drained", 32'(pops > 16), 1);
        do_reset();
        exp_q.delete();

        // Reset during PUSH1
        START = 1'b1;
        step();
        START = 1'b0;
        repeat (4) step();
        chk("rs_cnt_before", 32'(CAND_CNT), 1);
        RESET = 1'b1;
        step();
        chk("rs_valid", 32'(OUT_VALID), 0);
        chk("rs_busy", 32'(BUSY), 0);
        chk("rs_cand_cnt", 32'(CAND_CNT), 0);
        chk("rs_enum_rstn", 32'(ENUM_RSTn), 1);
        RESET = 1'b0;
        s0 = stb_cnt;
        repeat (10) step();
        chk("rs_no_stb", 32'(stb_cnt - s0), 0);
        chk("rs_idle", 32'(BUSY), 0);

        // Full randomized run with random backpressure and ignored mid-run STARTs
        seed = $urandom;
        ks = 1'($urandom_range(0, 1));
        use_stub = 1'b1;
        model_cnt = 0;
        for (int i = 0; i < 32768; i++) begin
            k = enum_key(i);
            for (int b = 0; b < 2; b++) begin
                if (model_f(((int'(k) << 1) | b) & 32'hFFFFF) == ks) begin
                    exp_q.push_back(21'((int'(k) << 1) | b));
                    model_cnt++;
                end
            end
        end
        s0 = stb_cnt;
        r0 = rstn_lo;
        pops = 0;
        sb_on = 1'b1;
        rand_ready = 1'b1;
        KS_BIT = ks;
        START = 1'b1;
        step();
        START = 1'b0;
        got_done = 1'b0;
        for (int c = 0; c < 140000 && !got_done; c++) begin
            if (c == 1000 || c == 60000) begin
                START = 1'b1;
                KS_BIT = ~ks;
            end
            step();
            START = 1'b0;
            KS_BIT = ks;
            if (DONE) got_done = 1'b1;
        end
        chk("run_done_seen", 32'(got_done), 1);
        chk("run_stb_pulses", 32'(stb_cnt - s0), 32768);
        chk("run_rstn_pulses", 32'(rstn_lo - r0), 1);
        chk("run_cand_cnt", 32'(CAND_CNT), 32'(model_cnt));
        chk("run_pops", 32'(pops), 32'(model_cnt));
        chk("run_queue_left", 32'(exp_q.size()), 0);
        chk("run_valid_at_done", 32'(OUT_VALID), 0);
        chk("run_busy_at_done", 32'(BUSY), 0);
        rand_ready = 1'b0;
        OUT_READY = 1'b0;
        repeat (3) step();
        chk("run_done_held", 32'(DONE), 1);
        sb_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
